wb_retire_unit: RTL

//  Writeback/retire stage of the pipelined MIPS core: owns the M->W pipeline register, extends load data,

---
 rtl/wb_retire_unit_pkg.sv | 19 +
 rtl/wb_retire_unit_load_ext.sv | 28 ++
 rtl/wb_retire_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_retire_unit_pkg.sv
// Shared writeback definitions: result-source and load-extension encodings.
package wb_retire_unit_pkg;

  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'd0,
    WB_SRC_MEM = 2'd1,
    WB_SRC_PC8 = 2'd2,
    WB_SRC_MD  = 2'd3
  } wb_src_e;

  typedef enum logic [2:0] {
    EXT_LW  = 3'd0,
    EXT_LBU = 3'd1,
    EXT_LB  = 3'd2,
    EXT_LHU = 3'd3,
    EXT_LH  = 3'd4
  } ext_e;

endpackage

// File: rtl/wb_retire_unit_load_ext.sv
// Load-data lane select and sign/zero extension for the W stage (purely combinational).
module wb_load_ext
  import wb_retire_unit_pkg::*;
(
  input  logic [2:0]  ext_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Low address bits pick the lane only; misalignment is not flagged here.
  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    case (ext_op)
      EXT_LBU: data = {24'b0, byte_sel};
      EXT_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      EXT_LHU: data = {16'b0, half_sel};
      EXT_LH:  data = {{16{half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_retire_unit.sv
// Writeback/retire stage: M->W register, load extension, RF write-port arbitration with late MDU FIFO.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_retire_unit
  import wb_retire_unit_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int MD_DEPTH = 2
`ifdef WB_RETIRE_CNT_EN
  ,
  parameter int CNT_W    = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_en,
  input  logic              w_flush,
  input  logic              m_valid,
  input  logic              m_regwrite,
  input  logic [REG_AW-1:0] m_waddr,
  input  logic [1:0]        m_src,
  input  logic [2:0]        m_extop,
  input  logic [31:0]       m_alu,
  input  logic [31:0]       m_rdata,
  input  logic [31:0]       m_pc8,
  input  logic [31:0]       m_md,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [REG_AW-1:0] md_waddr,
  input  logic [31:0]       md_data,
  output logic              md_pending,
  output logic [REG_AW-1:0] md_pend_addr,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              w_fwd_we
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]  retire_cnt
`endif
);

  localparam int PTR_W = $clog2(MD_DEPTH);

  logic              w_valid_q, w_valid_d;
  logic              w_regwrite_q, w_regwrite_d;
  logic [REG_AW-1:0] w_waddr_q, w_waddr_d;
  logic [1:0]        w_src_q, w_src_d;
  logic [2:0]        w_extop_q, w_extop_d;
  logic [31:0]       w_alu_q, w_alu_d;
  logic [31:0]       w_rdata_q, w_rdata_d;
  logic [31:0]       w_pc8_q, w_pc8_d;
  logic [31:0]       w_md_q, w_md_d;

  logic [31:0]       w_load_data;
  logic [31:0]       w_result;

  logic [REG_AW-1:0] fifo_addr_q [MD_DEPTH];
  logic [REG_AW-1:0] fifo_addr_d [MD_DEPTH];
  logic [31:0]       fifo_data_q [MD_DEPTH];
  logic [31:0]       fifo_data_d [MD_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic              fifo_empty, fifo_full;
  logic [REG_AW-1:0] head_addr;
  logic [31:0]       head_data;

  logic              pipe_req;
  logic              pop;
  logic              push;

  // M -> W capture: flush beats enable, otherwise hold
  always_comb begin
    w_valid_d    = w_valid_q;
    w_regwrite_d = w_regwrite_q;
    w_waddr_d    = w_waddr_q;
    w_src_d      = w_src_q;
    w_extop_d    = w_extop_q;
    w_alu_d      = w_alu_q;
    w_rdata_d    = w_rdata_q;
    w_pc8_d      = w_pc8_q;
    w_md_d       = w_md_q;
    if (w_flush) begin
      w_valid_d = 1'b0;
    end else if (w_en) begin
      w_valid_d    = m_valid;
      w_regwrite_d = m_regwrite;
      w_waddr_d    = m_waddr;
      w_src_d      = m_src;
      w_extop_d    = m_extop;
      w_alu_d      = m_alu;
      w_rdata_d    = m_rdata;
      w_pc8_d      = m_pc8;
      w_md_d       = m_md;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_valid_q <= 1'b0;
    end else begin
      w_valid_q <= w_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    w_regwrite_q <= w_regwrite_d;
    w_waddr_q    <= w_waddr_d;
    w_src_q      <= w_src_d;
    w_extop_q    <= w_extop_d;
    w_alu_q      <= w_alu_d;
    w_rdata_q    <= w_rdata_d;
    w_pc8_q      <= w_pc8_d;
    w_md_q       <= w_md_d;
  end

  wb_load_ext u_load_ext (
    .ext_op  (w_extop_q),
    .addr_lo (w_alu_q[1:0]),
    .rdata   (w_rdata_q),
    .data    (w_load_data)
  );

  always_comb begin
    w_result = w_alu_q;
    case (w_src_q)
      WB_SRC_ALU: w_result = w_alu_q;
      WB_SRC_MEM: w_result = w_load_data;
      WB_SRC_PC8: w_result = w_pc8_q;
      WB_SRC_MD:  w_result = w_md_q;
      default:    w_result = w_alu_q;
    endcase
  end

  // Late-result FIFO: extra pointer bit separates full from empty
  assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
  assign fifo_full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_addr    = fifo_addr_q[rd_ptr_q[PTR_W-1:0]];
  assign head_data    = fifo_data_q[rd_ptr_q[PTR_W-1:0]];
  assign md_pending   = ~fifo_empty;
  assign md_pend_addr = head_addr;
  assign w_fwd_we     = pipe_req;

  // Pipeline owns the port first; a FIFO entry for $0 is popped without writing.
  always_comb begin
    pipe_req = w_valid_q & w_regwrite_q & (w_waddr_q != '0);
    pop      = ~reset & ~pipe_req & ~fifo_empty;
    md_ready = ~fifo_full | pop;
    push     = md_valid & md_ready;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (~reset & pipe_req) begin
      rf_we    = 1'b1;
      rf_waddr = w_waddr_q;
      rf_wdata = w_result;
    end else if (pop) begin
      rf_we    = (head_addr != '0);
      rf_waddr = head_addr;
      rf_wdata = head_data;
    end
  end

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q + {{PTR_W{1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{PTR_W{1'b0}}, pop};
    if (push) begin
      fifo_addr_d[wr_ptr_q[PTR_W-1:0]] = md_waddr;
      fifo_data_d[wr_ptr_q[PTR_W-1:0]] = md_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  // A real instruction retires when it leaves W, whether replaced or flushed.
  always_comb begin
    retire_cnt_d = retire_cnt_q + CNT_W'(w_valid_q & (w_en | w_flush));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule
